lfsr_check: RTL and testbench
=============================

Name: lfsr_check

Overview:
- Galois LFSR sequence checker: the receive end of the project's pseudo-random generator.
- Consumes a stream of LFSR words and self-synchronises by seeding its predictor from the received data.
- Once locked, free-runs ("flywheels") its own LFSR, and flags and counts every word that does not match.
- Sits after a link, memory or DUT path under test in BIST and bring-up designs.

Parameters:
- LEN, 8: word / shift register length.
- TAPS, 8'b10111000: Galois XOR taps; must equal the generator's taps.
- LOCK_CNT, 4: consecutive matching words needed to enter LOCKED (≥1).
- LOSS_CNT, 4: consecutive mismatching words in LOCKED that drop lock (≥1).
- CNT_W, 16: error/word counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  data word valid this cycle
- data  in  LEN  received LFSR word
- clr  in  1  synchronous clear of err_cnt and word_cnt
- locked  out  1  checker is in LOCKED state
- err  out  1  one-cycle pulse: compared word mismatched
- err_cnt  out  CNT_W  saturating mismatch count
- word_cnt  out  CNT_W  saturating count of words compared in LOCKED (feature-dependent)

Behaviour:
- Step function: step(x) = {1'b0, x[LEN-1:1]} ^ (x[0] ? TAPS : 0).
- pred is the LEN-bit internal predictor register.
- All outputs are registered.
- Reset (async assert):
  - state SEARCH
  - pred all-ones
  - locked=0, err=0, err_cnt=0, word_cnt=0, match/miss counters 0
- No activity occurs when en=0: state and counters hold, and err=0.
- SEARCH, on en:
  - data==0: all-zero is an illegal LFSR state; stay in SEARCH.
  - Otherwise: pred<=step(data), match_cnt<=0, go to VERIFY.
- VERIFY, on en:
  - data==pred: match_cnt++ and pred<=step(data). If match_cnt+1==LOCK_CNT, go to LOCKED and clear miss_cnt.
  - data!=pred and data!=0: re-seed with pred<=step(data), match_cnt<=0, stay in VERIFY.
  - data==0: go to SEARCH.
  - No err pulses and no counting in SEARCH or VERIFY.
- LOCKED, on en:
  - pred<=step(pred) always (flywheel; never re-seeded from data).
  - Match: miss_cnt<=0.
  - Mismatch: err=1 next cycle, err_cnt++ (saturates at all-ones), miss_cnt++.
  - If miss_cnt+1==LOSS_CNT: go to SEARCH, locked<=0.
- Latency:
  - err and count updates appear the cycle after the en word.
  - locked rises the cycle after the LOCK_CNT-th consecutive match, i.e. after word LOCK_CNT+1 counting the seed word.
- clr:
  - Zeroes err_cnt and word_cnt next cycle.
  - clr wins over a simultaneous increment, but the err pulse still fires.
  - clr does not affect lock state.
- Reset mid-stream returns immediately to SEARCH; re-lock requires LOCK_CNT+1 valid words.

Optional Feature:
LFSR_CHECK_STATS_EN:
- Defined: word_cnt increments (saturating) on every en word in LOCKED, match or mismatch. This gives a BER denominator.
- Undefined: the word_cnt port remains but is tied to 0, with no counter logic.

Decomposition:
- Package lfsr_pkg:
  - typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} lfsr_check_state_t
  - shared step function usable by generator-side testbenches
- A single module is adequate. Optionally split a sub-module lfsr_check_sat_cnt (saturating counter with clear), instantiated for err_cnt and word_cnt.

Test Plan:
- Lock: feed en words 0xFF, 0xC7, 0xDB, 0xD5, 0xD2 (defaults) -> locked=1 on the cycle after 0xD2, err never asserted, err_cnt=0.
- Single error: from lock, send 0x00 (expected 0x69), then 0x8C -> one err pulse, err_cnt=1, locked stays 1, and 0x8C matches (flywheel).
- Loss: from lock, send 4 consecutive wrong words -> err pulses 4 times, err_cnt=4, locked falls after the 4th. Then sending 0x00 keeps state in SEARCH.
- Re-seed in VERIFY: 0xFF, 0xC7, 0x12, then a correct run from 0x12 onward -> no lock until 4 matches after 0x12. err stays 0 throughout.
- Saturation/clr: CNT_W=4, 20 errors while LOSS_CNT is large -> err_cnt holds 0xF. Asserting clr together with an error -> err_cnt=0 next cycle, err=1.
- Async reset mid-lock plus en gaps: assert rst between clock edges -> locked=0 immediately. Idle cycles with en=0 while locked -> no state change.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the Galois LFSR generator/checker pair.
//   - lfsr_check_state_t : checker FSM states (SEARCH, VERIFY, LOCKED)
//   - lfsr_step()        : one Galois step, usable by the generator side and
//                          by testbenches. Operates on a zero-extended 64-bit
//                          word, so any LEN <= 64 works; callers truncate the
//                          result back to LEN bits.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_check_state_t;

  localparam int unsigned LFSR_MAX_W = 64;

  // step(x) = {0, x[LEN-1:1]} ^ (x[0] ? TAPS : 0). With x zero-extended,
  // a plain right shift shifts a zero into bit LEN-1.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] x,
    input logic [LFSR_MAX_W-1:0] taps
  );
    lfsr_step = (x >> 1) ^ (x[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_check_sat_cnt.sv
// lfsr_check_sat_cnt: saturating up-counter with synchronous clear.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset (count -> 0)
//   clr_i  in  synchronous clear; wins over a simultaneous increment
//   inc_i  in  increment request; ignored once the count is all-ones
//   cnt_o  out registered count
module lfsr_check_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && ~&cnt_q)     cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_check.sv
// lfsr_check: Galois LFSR sequence checker (receive side of the PRBS pair).
// Seeds its predictor from received data, verifies LOCK_CNT consecutive
// matches, then flywheels its own LFSR and flags/counts every mismatch.
//
// Optional feature macro: LFSR_CHECK_STATS_EN
//   defined   : word_cnt counts (saturating) every en word seen in LOCKED
//   undefined : word_cnt is tied to zero
//
// Input qualifier: en is a valid-only strobe with no back-pressure; the
// checker consumes data on every cycle en is high and ignores it otherwise.
//
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   en        in  data word valid this cycle
//   data      in  received LFSR word [LEN-1:0]
//   clr       in  synchronous clear of err_cnt and word_cnt
//   locked    out checker is in LOCKED
//   err       out one-cycle pulse: a LOCKED-state word mismatched
//   err_cnt   out saturating mismatch count [CNT_W-1:0]
//   word_cnt  out saturating LOCKED word count [CNT_W-1:0]
//   dbg_state out current FSM state (debug observation)
module lfsr_check
  import lfsr_pkg::*;
#(
  parameter int unsigned     LEN      = 8,
  parameter logic [LEN-1:0]  TAPS     = 8'b10111000,
  parameter int unsigned     LOCK_CNT = 4,
  parameter int unsigned     LOSS_CNT = 4,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LEN-1:0]    data,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output lfsr_check_state_t dbg_state
);

  // Wide enough to hold LOCK_CNT / LOSS_CNT themselves.
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  function automatic logic [LEN-1:0] step(input logic [LEN-1:0] x);
    step = LEN'(lfsr_step(LFSR_MAX_W'(x), LFSR_MAX_W'(TAPS)));
  endfunction

  lfsr_check_state_t state_q, state_d;
  logic [LEN-1:0]    pred_q, pred_d;
  logic [MW-1:0]     match_q, match_d;
  logic [LW-1:0]     miss_q, miss_d;
  logic              err_q, err_d;
  logic              locked_q;
  logic              err_inc;

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    err_inc = 1'b0;
    if (en) begin
      case (state_q)
        SEARCH: begin
          // All-zero is the LFSR lock-up state and can never be a valid seed.
          if (data != '0) begin
            pred_d  = step(data);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (data == '0) begin
            state_d = SEARCH;
          end else if (data == pred_q) begin
            match_d = match_q + MW'(1);
            pred_d  = step(data);
            if (match_q + MW'(1) == MW'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            // Wrong but legal word: assume we seeded on corrupted data and
            // restart verification from this word.
            pred_d  = step(data);
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: never re-seed from data once locked, so a burst of
          // errors cannot drag the predictor off the true sequence.
          pred_d = step(pred_q);
          if (data != pred_q) begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_q + LW'(1);
            if (miss_q + LW'(1) == LW'(LOSS_CNT)) state_d = SEARCH;
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      pred_q   <= '1;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  lfsr_check_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (err_inc),
    .cnt_o (err_cnt)
  );

`ifdef LFSR_CHECK_STATS_EN
  logic word_inc;
  assign word_inc = en && (state_q == LOCKED);

  lfsr_check_sat_cnt #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (word_inc),
    .cnt_o (word_cnt)
  );
`else
  assign word_cnt = '0;
`endif

  assign locked    = locked_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_check.sv
// tb_lfsr_check: directed self-checking bench for lfsr_check.
// u_dut uses default parameters; u_sat uses CNT_W=4, LOSS_CNT=31 for the
// saturation/clear scenario. Both share all inputs.
module tb_lfsr_check;
  import lfsr_pkg::*;

`ifdef LFSR_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data = 8'h00;

  always #5 clk = ~clk;

  logic              d_locked, d_err;
  logic [15:0]       d_err_cnt, d_word_cnt;
  lfsr_check_state_t d_state;
  logic              s_locked, s_err;
  logic [3:0]        s_err_cnt, s_word_cnt;
  lfsr_check_state_t s_state;

  lfsr_check u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data      (data),
    .clr       (clr),
    .locked    (d_locked),
    .err       (d_err),
    .err_cnt   (d_err_cnt),
    .word_cnt  (d_word_cnt),
    .dbg_state (d_state)
  );

  lfsr_check #(.LOSS_CNT(31), .CNT_W(4)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data      (data),
    .clr       (clr),
    .locked    (s_locked),
    .err       (s_err),
    .err_cnt   (s_err_cnt),
    .word_cnt  (s_word_cnt),
    .dbg_state (s_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, sample 1 ns after the rising edge that
  // consumed the word.
  task automatic send(input logic e, input logic [7:0] d, input logic c);
    @(negedge clk);
    en   = e;
    data = d;
    clr  = c;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  // Hand-computed default sequence (TAPS=0xB8) starting at 0xFF.
  logic [7:0] lock_seq [5] = '{8'hFF, 8'hC7, 8'hDB, 8'hD5, 8'hD2};
  // Re-seed run from 0x12: 0x12 -> 0x09 -> 0xBC -> 0x5E -> 0x2F
  logic [7:0] reseed_seq [7] = '{8'hFF, 8'hC7, 8'h12, 8'h09, 8'hBC, 8'h5E, 8'h2F};

  initial begin
    // ---- reset state ----
    #1 rst = 1'b1;
    #2;
    check("rst_locked",   d_locked,   0);
    check("rst_err",      d_err,      0);
    check("rst_err_cnt",  d_err_cnt,  0);
    check("rst_word_cnt", d_word_cnt, 0);
    check("rst_state",    d_state,    SEARCH);
    @(negedge clk) rst = 1'b0;

    // ---- lock ----
    for (int i = 0; i < 5; i++) begin
      send(1'b1, lock_seq[i], 1'b0);
      check("lock_err", d_err, 0);
      check("lock_locked", d_locked, (i == 4) ? 1 : 0);
    end
    check("lock_err_cnt", d_err_cnt, 0);
    check("lock_word_cnt", d_word_cnt, 0);

    // ---- single error, then flywheel match ----
    send(1'b1, 8'h00, 1'b0);               // expected 0x69
    check("se_err", d_err, 1);
    check("se_err_cnt", d_err_cnt, 1);
    check("se_locked", d_locked, 1);
    send(1'b1, 8'h8C, 1'b0);
    check("se_match_err", d_err, 0);
    check("se_match_cnt", d_err_cnt, 1);
    check("se_word_cnt", d_word_cnt, STATS ? 2 : 0);

    // ---- idle cycles while locked: nothing moves ----
    send(1'b0, 8'h00, 1'b0);
    send(1'b0, 8'h55, 1'b0);
    check("idle_err", d_err, 0);
    check("idle_locked", d_locked, 1);
    check("idle_err_cnt", d_err_cnt, 1);
    send(1'b1, 8'h46, 1'b0);               // predictor must not have advanced
    check("idle_next_err", d_err, 0);
    check("idle_word_cnt", d_word_cnt, STATS ? 3 : 0);

    // ---- loss of lock: 4 consecutive wrong words ----
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'h00, 1'b0);
      check("loss_err", d_err, 1);
      check("loss_err_cnt", d_err_cnt, 32'(2 + i));
      check("loss_locked", d_locked, (i == 3) ? 0 : 1);
    end
    send(1'b1, 8'h00, 1'b0);
    check("loss_zero_state", d_state, SEARCH);
    check("loss_zero_err", d_err, 0);
    check("loss_zero_cnt", d_err_cnt, 5);

    // ---- clr without en ----
    send(1'b0, 8'h00, 1'b1);
    check("clr_err_cnt", d_err_cnt, 0);
    check("clr_word_cnt", d_word_cnt, 0);

    // ---- re-seed in VERIFY ----
    for (int i = 0; i < 7; i++) begin
      send(1'b1, reseed_seq[i], 1'b0);
      check("rs_err", d_err, 0);
      check("rs_locked", d_locked, (i == 6) ? 1 : 0);
    end
    check("rs_err_cnt", d_err_cnt, 0);

    // ---- async reset between clock edges ----
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_locked", d_locked, 0);
    check("arst_state", d_state, SEARCH);
    @(negedge clk) rst = 1'b0;

    // ---- re-lock (both DUTs), then saturation on u_sat ----
    for (int i = 0; i < 5; i++) begin
      send(1'b1, lock_seq[i], 1'b0);
      check("relock_locked", d_locked, (i == 4) ? 1 : 0);
    end
    check("sat_locked0", s_locked, 1);
    for (int i = 1; i <= 20; i++) begin
      send(1'b1, 8'h00, 1'b0);
      if (i == 14) check("sat_cnt14", s_err_cnt, 14);
      if (i == 15) check("sat_cnt15", s_err_cnt, 15);
      if (i == 20) begin
        check("sat_cnt20", s_err_cnt, 15);
        check("sat_err20", s_err, 1);
        check("sat_locked20", s_locked, 1);
        check("sat_word20", s_word_cnt, STATS ? 15 : 0);
      end
    end
    send(1'b1, 8'h00, 1'b1);               // error together with clr
    check("sat_clr_cnt", s_err_cnt, 0);
    check("sat_clr_err", s_err, 1);
    check("sat_clr_word", s_word_cnt, 0);
    send(1'b1, 8'h00, 1'b0);
    check("sat_post_cnt", s_err_cnt, 1);
    check("sat_post_word", s_word_cnt, STATS ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
